// File: rtl/call_issuer_if.sv
// Bundle of core-side call request/response and handler-side strobe/ack signals.
// master = the issuer; slave = the core plus helper handler it talks to.
interface call_issuer_if;
  logic        call_valid;
  logic        call_ready;
  logic [63:0] call_func;
  logic [63:0] call_r1;
  logic [63:0] call_r2;
  logic [63:0] call_r3;
  logic [63:0] call_r4;
  logic [63:0] call_r5;
  logic        done;
  logic        done_err;
  logic        done_timeout;
  logic [63:0] r0_out;
  logic [63:0] func;
  logic        stb;
  logic [63:0] r1;
  logic [63:0] r2;
  logic [63:0] r3;
  logic [63:0] r4;
  logic [63:0] r5;
  logic        ack;
  logic        err;
  logic [63:0] ret;

  modport master (
    input  call_valid, call_func, call_r1, call_r2, call_r3, call_r4, call_r5,
    input  ack, err, ret,
    output call_ready, done, done_err, done_timeout, r0_out,
    output func, stb, r1, r2, r3, r4, r5
  );

  modport slave (
    output call_valid, call_func, call_r1, call_r2, call_r3, call_r4, call_r5,
    output ack, err, ret,
    input  call_ready, done, done_err, done_timeout, r0_out,
    input  func, stb, r1, r2, r3, r4, r5
  );
endinterface

// File: rtl/call_issuer.sv
// Initiator of the eBPF helper-call strobe/ack protocol: latches one CALL,
// strobes the handler, returns R0 with error/timeout status and a bounded wait.
module call_issuer #(
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [63:0] RET_ON_ERR = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  call_issuer_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  logic [1:0]  state_q, state_d;
  logic        stb_q, stb_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        to_flag_q, to_flag_d;
  logic        done_q, done_d;
  logic        done_err_q, done_err_d;
  logic        done_to_q, done_to_d;
  logic [63:0] func_q, func_d;
  logic [63:0] r0_q, r0_d;
  logic [63:0] arg_q [5];
  logic [63:0] arg_d [5];
  logic [63:0] call_args [5];

  assign call_args[0] = bus.call_r1;
  assign call_args[1] = bus.call_r2;
  assign call_args[2] = bus.call_r3;
  assign call_args[3] = bus.call_r4;
  assign call_args[4] = bus.call_r5;

  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    to_flag_d  = to_flag_q;
    func_d     = func_q;
    r0_d       = r0_q;
    arg_d      = arg_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    done_to_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.call_valid) begin
          func_d     = bus.call_func;
          arg_d      = call_args;
          stb_d      = 1'b1;
          cnt_d      = '0;
          err_flag_d = 1'b0;
          to_flag_d  = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        // ack has priority over a timeout expiring in the same cycle
        if (bus.ack) begin
          err_flag_d = bus.err;
          r0_d       = bus.err ? RET_ON_ERR : bus.ret;
          stb_d      = 1'b0;
          state_d    = S_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          to_flag_d = 1'b1;
          r0_d      = RET_ON_ERR;
          stb_d     = 1'b0;
          state_d   = S_RELEASE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RELEASE: begin
        // Hold off until the handler drops ack so the next stb cannot alias it
        if (!bus.ack) begin
          done_d     = 1'b1;
          done_err_d = err_flag_q;
          done_to_d  = to_flag_q;
          state_d    = S_IDLE;
        end
      end
      default: begin
        stb_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      stb_q      <= 1'b0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      to_flag_q  <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      done_to_q  <= 1'b0;
      func_q     <= '0;
      r0_q       <= '0;
      for (int i = 0; i < 5; i++) arg_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      to_flag_q  <= to_flag_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      done_to_q  <= done_to_d;
      func_q     <= func_d;
      r0_q       <= r0_d;
      for (int i = 0; i < 5; i++) arg_q[i] <= arg_d[i];
    end
  end

  assign bus.call_ready   = (state_q == S_IDLE);
  assign bus.done         = done_q;
  assign bus.done_err     = done_err_q;
  assign bus.done_timeout = done_to_q;
  assign bus.r0_out       = r0_q;
  assign bus.func         = func_q;
  assign bus.stb          = stb_q;
  assign bus.r1           = arg_q[0];
  assign bus.r2           = arg_q[1];
  assign bus.r3           = arg_q[2];
  assign bus.r4           = arg_q[3];
  assign bus.r5           = arg_q[4];

endmodule

// File: tb/tb_call_issuer.sv
// Directed bench for call_issuer: a cycle-stepped handler model answers stb,
// each test task checks its own expectations inline.
module tb_call_issuer;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // handler model state
  int          h_delay;
  int          h_hold;
  logic        h_err;
  logic [63:0] h_ret;
  int          h_k;
  int          h_z;

  call_issuer_if bus();

  call_issuer #(.TIMEOUT(8), .RET_ON_ERR(ONES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Called once per negedge: acks h_delay cycles after stb is seen, and
  // drops ack h_hold cycles after stb falls (registered-handler behaviour).
  task automatic handler_step();
    if (bus.stb) begin
      h_z = 0;
      h_k++;
      if (h_delay >= 0 && h_k == h_delay + 1) begin
        bus.ack = 1'b1;
        bus.err = h_err;
        bus.ret = h_ret;
      end
    end else begin
      h_k = 0;
      if (bus.ack) begin
        h_z++;
        if (h_z == h_hold + 1) begin
          bus.ack = 1'b0;
          bus.err = 1'b0;
          bus.ret = '0;
          h_z     = 0;
        end
      end
    end
  endtask

  task automatic run_call(input logic [63:0] f, input logic [63:0] a1, input int dly,
                          input logic e, input logic [63:0] rv, input int hold,
                          output int stb_cyc, output int ready_hi, output logic got_done,
                          output logic d_err, output logic d_to, output logic [63:0] r0,
                          output logic [63:0] r1_seen);
    h_delay = dly; h_hold = hold; h_err = e; h_ret = rv; h_k = 0; h_z = 0;
    bus.call_func = f;
    bus.call_r1 = a1; bus.call_r2 = a1 + 1; bus.call_r3 = a1 + 2;
    bus.call_r4 = a1 + 3; bus.call_r5 = a1 + 4;
    bus.call_valid = 1'b1;
    @(negedge clk);
    bus.call_valid = 1'b0;
    stb_cyc = 0; ready_hi = 0; got_done = 1'b0;
    d_err = 1'b0; d_to = 1'b0; r0 = '0; r1_seen = bus.r1;
    for (int i = 0; i < 100 && !got_done; i++) begin
      if (bus.done) begin
        got_done = 1'b1;
        d_err    = bus.done_err;
        d_to     = bus.done_timeout;
        r0       = bus.r0_out;
      end else begin
        if (bus.stb) stb_cyc++;
        if (bus.call_ready) ready_hi++;
        handler_step();
        @(negedge clk);
      end
    end
    $display("call func=%h r1=%h stb_cycles=%0d done=%0b err=%0b timeout=%0b r0=%h",
             f, a1, stb_cyc, got_done, d_err, d_to, r0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.call_valid = 1'b0; bus.call_func = '0;
    bus.call_r1 = '0; bus.call_r2 = '0; bus.call_r3 = '0; bus.call_r4 = '0; bus.call_r5 = '0;
    bus.ack = 1'b0; bus.err = 1'b0; bus.ret = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b expected 0", bus.stb); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.r0_out !== 64'h0) begin n_fail++; $display("FAIL reset_r0: got %h expected 0", bus.r0_out); end
    n_checks++; if (bus.func !== 64'h0) begin n_fail++; $display("FAIL reset_func: got %h expected 0", bus.func); end
    n_checks++; if (bus.call_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.call_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_led();
    int sc, rh; logic gd, de, dt; logic [63:0] r0, r1s;
    run_call(64'hff000001, 64'd5, 1, 1'b0, 64'h0, 1, sc, rh, gd, de, dt, r0, r1s);
    n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL led_done: got %b expected 1", gd); end
    n_checks++; if (sc != 2) begin n_fail++; $display("FAIL led_stb_cycles: got %0d expected 2", sc); end
    n_checks++; if (r1s !== 64'd5) begin n_fail++; $display("FAIL led_r1: got %h expected 5", r1s); end
    n_checks++; if (de !== 1'b0 || dt !== 1'b0) begin n_fail++; $display("FAIL led_status: got err=%b to=%b expected 0 0", de, dt); end
    n_checks++; if (r0 !== 64'h0) begin n_fail++; $display("FAIL led_r0: got %h expected 0", r0); end
    n_checks++; if (bus.r5 !== 64'd9) begin n_fail++; $display("FAIL led_r5: got %h expected 9", bus.r5); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0 || bus.done_err !== 1'b0) begin n_fail++; $display("FAIL led_done_pulse: got done=%b err=%b expected 0 0", bus.done, bus.done_err); end
    n_checks++; if (bus.func !== 64'hff000001) begin n_fail++; $display("FAIL led_func_hold: got %h expected ff000001", bus.func); end
  endtask

  task automatic test_load();
    int sc, rh; logic gd, de, dt; logic [63:0] r0, r1s;
    run_call(64'hff000003, 64'h100, 3, 1'b0, 64'h1234, 1, sc, rh, gd, de, dt, r0, r1s);
    n_checks++; if (sc != 4) begin n_fail++; $display("FAIL load_stb_cycles: got %0d expected 4", sc); end
    n_checks++; if (r0 !== 64'h1234) begin n_fail++; $display("FAIL load_r0: got %h expected 1234", r0); end
    n_checks++; if (rh != 0) begin n_fail++; $display("FAIL load_ready_busy: got %0d ready cycles expected 0", rh); end
    n_checks++; if (gd !== 1'b1 || de !== 1'b0 || dt !== 1'b0) begin n_fail++; $display("FAIL load_status: got done=%b err=%b to=%b expected 1 0 0", gd, de, dt); end
    @(negedge clk);
  endtask

  task automatic test_err();
    int sc, rh; logic gd, de, dt; logic [63:0] r0, r1s;
    run_call(64'h42, 64'h7, 1, 1'b1, 64'h55, 1, sc, rh, gd, de, dt, r0, r1s);
    n_checks++; if (gd !== 1'b1 || de !== 1'b1) begin n_fail++; $display("FAIL err_done_err: got done=%b err=%b expected 1 1", gd, de); end
    n_checks++; if (dt !== 1'b0) begin n_fail++; $display("FAIL err_timeout: got %b expected 0", dt); end
    n_checks++; if (r0 !== ONES) begin n_fail++; $display("FAIL err_r0: got %h expected %h", r0, ONES); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int sc, rh; logic gd, de, dt; logic [63:0] r0, r1s;
    run_call(64'hff000002, 64'h3, -1, 1'b0, 64'h0, 1, sc, rh, gd, de, dt, r0, r1s);
    n_checks++; if (sc != 8) begin n_fail++; $display("FAIL to_stb_cycles: got %0d expected 8", sc); end
    n_checks++; if (gd !== 1'b1 || dt !== 1'b1 || de !== 1'b0) begin n_fail++; $display("FAIL to_status: got done=%b to=%b err=%b expected 1 1 0", gd, dt, de); end
    n_checks++; if (r0 !== ONES) begin n_fail++; $display("FAIL to_r0: got %h expected %h", r0, ONES); end
    @(negedge clk);
    bus.ack = 1'b1; bus.ret = 64'h77;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.stb !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL late_ack_idle: got stb=%b done=%b expected 0 0", bus.stb, bus.done); end
    n_checks++; if (bus.r0_out !== ONES || bus.call_ready !== 1'b1) begin n_fail++; $display("FAIL late_ack_state: got r0=%h ready=%b expected %h 1", bus.r0_out, bus.call_ready, ONES); end
    bus.ack = 1'b0; bus.ret = '0;
    @(negedge clk);
    $display("late ack in idle ignored");
  endtask

  task automatic test_back_to_back();
    int rises = 0, dones = 0, bad = 0;
    logic prev_stb = 1'b0;
    h_delay = 1; h_hold = 2; h_err = 1'b0; h_ret = 64'hABCD; h_k = 0; h_z = 0;
    bus.call_func = 64'hff000001; bus.call_r1 = 64'h11;
    bus.call_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.stb && !prev_stb) begin
        rises++;
        if (bus.ack) bad++;
        if (rises == 2) bus.call_valid = 1'b0;
      end
      if (bus.done) begin
        dones++;
        $display("b2b done #%0d r0=%h", dones, bus.r0_out);
      end
      prev_stb = bus.stb;
      handler_step();
    end
    bus.call_valid = 1'b0;
    n_checks++; if (rises != 2) begin n_fail++; $display("FAIL b2b_stb_rises: got %0d expected 2", rises); end
    n_checks++; if (dones != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_stb_under_ack: got %0d expected 0", bad); end
    n_checks++; if (bus.r0_out !== 64'hABCD) begin n_fail++; $display("FAIL b2b_r0: got %h expected abcd", bus.r0_out); end
  endtask

  task automatic test_reset_mid_req();
    int sc, rh; logic gd, de, dt; logic [63:0] r0, r1s;
    bus.call_func = 64'hff000002; bus.call_r1 = 64'h21;
    bus.call_valid = 1'b1;
    @(negedge clk);
    bus.call_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.stb !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stb: got %b expected 1", bus.stb); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.stb !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stb: got %b expected 0", bus.stb); end
    n_checks++; if (bus.r0_out !== 64'h0) begin n_fail++; $display("FAIL rst_mid_r0: got %h expected 0", bus.r0_out); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", bus.done); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset during REQ, call discarded");
    run_call(64'hff000003, 64'h30, 2, 1'b0, 64'h99, 1, sc, rh, gd, de, dt, r0, r1s);
    n_checks++; if (gd !== 1'b1 || r0 !== 64'h99) begin n_fail++; $display("FAIL rst_recover: got done=%b r0=%h expected 1 99", gd, r0); end
    n_checks++; if (sc != 3) begin n_fail++; $display("FAIL rst_recover_stb: got %0d expected 3", sc); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_load();
    test_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/call_issuer.md
Name: call_issuer

Overview:
- Initiator side of the eBPF helper-call strobe/ack protocol; the counterpart of the helper call handler.
- Sits between the eBPF core execute stage and the helper call handler.
- Accepts one CALL request from the core (function id plus R1-R5), then drives func/stb/r1-r5 to the handler and waits for ack/err.
- Returns the handler's ret as R0 to the core, with error and timeout status and a bounded wait.

Parameters:
- TIMEOUT, 1024, max cycles stb may stay high without ack before the call is aborted; valid range 2..65535.
- RET_ON_ERR, 64'hFFFF_FFFF_FFFF_FFFF, value written to r0_out when a call ends in err or timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- call_valid  in  1  core requests a helper call
- call_ready  out  1  issuer can accept a call (IDLE only)
- call_func  in  64  helper id, e.g. 0xff000001 (LED), 0xff000002 (store), 0xff000003 (load)
- call_r1..call_r5  in  64 each  argument registers R1-R5
- done  out  1  one-cycle pulse: call finished
- done_err  out  1  valid with done: handler returned err
- done_timeout  out  1  valid with done: TIMEOUT expired
- r0_out  out  64  returned R0, held until the next done
- func  out  64  function id to handler
- stb  out  1  call strobe to handler
- r1..r5  out  64 each  argument registers to handler
- ack  in  1  handler acknowledge
- err  in  1  handler error, qualified by ack
- ret  in  64  handler return value, valid when ack=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE; stb=0; func, r1-r5, r0_out = 0; done, done_err, done_timeout = 0; timeout counter = 0. Reset mid-call drops stb immediately and discards the call with no done.
- Handshake: call_ready=1 only in IDLE. A call is accepted on the edge where call_valid & call_ready.
- States:
  - IDLE: on accept, register call_func→func and call_r1..5→r1..5, set stb=1, clear counter, go REQ. stb rises the cycle after accept. func and r1-r5 stay stable until the next accept.
  - REQ: stb=1; counter increments each cycle.
    - If ack=1: capture err into an error flag. If err=0, capture ret→r0_out; if err=1, load RET_ON_ERR→r0_out. Drop stb next cycle, go RELEASE.
    - Else if counter==TIMEOUT-1: drop stb, set the timeout flag, load RET_ON_ERR, go RELEASE.
    - ack wins if ack and the timeout occur in the same cycle.
  - RELEASE: stb=0; wait until ack=0, because the handler clears ack one cycle after stb falls. When ack=0, pulse done for one cycle with done_err/done_timeout from the flags, then go IDLE.
  - done_err and done_timeout are 0 whenever done=0.
- No second stb is raised while ack is still high; back-to-back calls are therefore ≥4 cycles apart.
- Multi-cycle handlers (store/load take 2-3 cycles before ack) need no special handling; stb simply stays high.
- An ack that arrives in IDLE is ignored.
- call_valid held high in a non-IDLE state is not accepted until IDLE.
- Counter width is 16 bits and saturates; no wrap.

Test Plan:
1. LED call: call_func=0xff000001, call_r1=5; handler acks 1 cycle after stb with err=0, ret=0 → stb high exactly 2 cycles; handler outputs r1=5; done pulse with done_err=0, done_timeout=0; r0_out=ret.
2. Load call: handler acks 3 cycles after stb with ret=64'h1234 → stb stays high 4 cycles; r0_out=64'h1234 at done; call_ready=0 throughout.
3. Unknown func 0x42: handler acks with err=1 → done_err=1, r0_out=RET_ON_ERR, done_timeout=0.
4. Timeout, TIMEOUT=8: ack never asserts → stb falls after exactly 8 cycles high; done_timeout=1, r0_out=RET_ON_ERR; a late ack in IDLE is ignored.
5. Back-to-back: call_valid held high for two calls; handler keeps ack high 2 cycles after stb falls → second stb rises only after ack=0; exactly two done pulses.
6. Reset mid-REQ: rst_n low while stb=1 → stb=0 and r0_out=0 immediately, no done; after release, a new call completes normally.
